// File: rtl/button_debounce_if.sv
// Button bus between the raw pins and the debouncer.
//   button_in     : raw, asynchronous button pins (driven by master)
//   out_port      : debounced level, same polarity as button_in
//   press_pulse   : one-cycle strobe on a committed transition to pressed
//   release_pulse : one-cycle strobe on a committed transition to idle
// master = pin/consumer side, slave = the debouncer.
interface button_debounce_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] button_in;
  logic [WIDTH-1:0] out_port;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;

  modport master (
    output button_in,
    input  out_port,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  button_in,
    output out_port,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/button_debounce.sv
// Multi-channel push-button synchronizer and debouncer.
// Each channel: 2-FF synchronizer, then a stability counter that commits a
// new level only after DEBOUNCE_CYCLES consecutive equal samples.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous, active-low reset
//   bus     : button_debounce_if.slave (button_in in; out_port,
//             press_pulse, release_pulse out)
// out_port keeps raw pin polarity; reset drives everything to the idle level
// so no transition is seen downstream on reset release.
module button_debounce #(
  parameter int WIDTH           = 3,
  parameter int CNT_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  button_debounce_if.slave bus
);

  localparam logic ST_STABLE   = 1'b0;
  localparam logic ST_COUNTING = 1'b1;

  localparam logic IDLE_LVL  = (ACTIVE_LOW != 0);
  localparam logic PRESS_LVL = ~IDLE_LVL;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     sync1_q;
  logic [WIDTH-1:0]     sync2_q;
  logic [WIDTH-1:0]     out_q;
  logic [WIDTH-1:0]     press_q;
  logic [WIDTH-1:0]     release_q;
  logic [WIDTH-1:0]     state_q;
  logic [WIDTH-1:0]     state_d;
  logic [WIDTH-1:0]     commit;
  logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d [WIDTH];

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      commit[i]  = 1'b0;
      unique case (state_q[i])
        ST_STABLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i] != out_q[i]) begin
            // A one-sample threshold needs no counting phase.
            if (DEBOUNCE_CYCLES == 1) begin
              commit[i] = 1'b1;
            end else begin
              state_d[i] = ST_COUNTING;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        ST_COUNTING: begin
          if (sync2_q[i] == out_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            commit[i]  = 1'b1;
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= {WIDTH{IDLE_LVL}};
      sync2_q   <= {WIDTH{IDLE_LVL}};
      out_q     <= {WIDTH{IDLE_LVL}};
      press_q   <= '0;
      release_q <= '0;
      state_q   <= {WIDTH{ST_STABLE}};
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.button_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      // Committed bits take the registered sync2 level; others hold.
      out_q     <= (out_q & ~commit) | (sync2_q & commit);
      press_q   <= commit & ~(sync2_q ^ {WIDTH{PRESS_LVL}});
      release_q <= commit & ~(sync2_q ^ {WIDTH{IDLE_LVL}});
    end
  end

  assign bus.out_port      = out_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;

endmodule
